// File: rtl/regfile_write_queue.sv
// Buffered write-back queue for the 16-entry register file: merges load and ALU writes in order,
// drains one per cycle onto A3/WD3/WE3, and reports pending-write hazards. Forwarding: REGFILE_WQ_FORWARD_EN.
module regfile_write_queue #(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       MEM_VALID,
  output logic                       MEM_READY,
  input  logic [3:0]                 MEM_ADDR,
  input  logic [31:0]                MEM_DATA,
  input  logic                       ALU_VALID,
  output logic                       ALU_READY,
  input  logic [3:0]                 ALU_ADDR,
  input  logic [31:0]                ALU_DATA,
  output logic [3:0]                 A3,
  output logic [31:0]                WD3,
  output logic                       WE3,
  input  logic [3:0]                 A1,
  input  logic [3:0]                 A2,
  output logic                       PEND1,
  output logic                       PEND2,
  output logic [31:0]                FD1,
  output logic [31:0]                FD2,
  output logic                       FV1,
  output logic                       FV2,
  output logic [$clog2(DEPTH):0]     COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    PC_ADDR = 4'd15;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_OFF = CW'(DEPTH - 1);
  localparam logic [CW-1:0] TWO_OFF = CW'(DEPTH - 2);

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t          entries [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;

  logic            mem_push;
  logic            alu_push;
  logic            pop;
  logic [PW-1:0]   alu_slot;
  logic [CW-1:0]   push_cnt;
  entry_t          head_entry;

  // Readiness looks only at the registered count, so a slot freed by this
  // cycle's drain is not offered until next cycle; reset forces both low.
  assign MEM_READY = RESET_N & (count_q < FULL);
  assign ALU_READY = RESET_N & ((count_q <= TWO_OFF) | ((count_q == ONE_OFF) & ~MEM_VALID));

  // PC-targeted writes complete the handshake but never occupy a slot.
  assign mem_push = MEM_VALID & MEM_READY & (MEM_ADDR != PC_ADDR);
  assign alu_push = ALU_VALID & ALU_READY & (ALU_ADDR != PC_ADDR);
  assign pop      = (count_q != '0);
  assign alu_slot = mem_push ? tail_q + PW'(1) : tail_q;
  assign push_cnt = CW'(mem_push) + CW'(alu_push);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // A push can never target the slot being retired: pushing needs a free slot.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (mem_push) valid_q[tail_q]   <= 1'b1;
      if (alu_push) valid_q[alu_slot] <= 1'b1;
      tail_q  <= tail_q + PW'(push_cnt);
      count_q <= count_q + push_cnt - CW'(pop);
    end
  end

  // NOTE: the payload array carries no reset; valid_q alone decides whether an entry is live.
  always_ff @(posedge CLK) begin
    if (mem_push) entries[tail_q]   <= '{addr: MEM_ADDR, data: MEM_DATA};
    if (alu_push) entries[alu_slot] <= '{addr: ALU_ADDR, data: ALU_DATA};
  end

  assign head_entry = entries[head_q];
  assign WE3   = pop;
  assign A3    = pop ? head_entry.addr : '0;
  assign WD3   = pop ? head_entry.data : '0;
  assign COUNT = count_q;

  function automatic logic pending(input logic [3:0] a);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entries[i].addr == a)) hit = 1'b1;
    end
    return hit & (a != PC_ADDR);
  endfunction

  assign PEND1 = pending(A1);
  assign PEND2 = pending(A2);

`ifdef REGFILE_WQ_FORWARD_EN
  // Walk from head (oldest) to tail so the last match is the youngest write.
  function automatic logic [31:0] youngest_data(input logic [3:0] a);
    logic [31:0]   d;
    logic [PW-1:0] idx;
    d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (entries[idx].addr == a)) d = entries[idx].data;
    end
    return d;
  endfunction

  assign FV1 = PEND1;
  assign FV2 = PEND2;
  assign FD1 = PEND1 ? youngest_data(A1) : '0;
  assign FD2 = PEND2 ? youngest_data(A2) : '0;
`else
  assign FV1 = 1'b0;
  assign FV2 = 1'b0;
  assign FD1 = '0;
  assign FD2 = '0;
`endif

endmodule
